// File: rtl/parity_frame_rx_pkg.sv
// parity_frame_rx_pkg: shared state encoding and default frame width
package parity_frame_rx_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
    localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/parity_frame_rx_par_acc.sv
// par_acc: running XOR register; clear and accumulate in one cycle loads d
module par_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else     q <= (clr ? 1'b0 : q) ^ (en & d);
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial LSB-first frame receiver with trailing parity bit check
import parity_frame_rx_pkg::*;
module parity_frame_rx #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_vld,
    output logic              parity_err,
    output logic              abort,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [DATA_W-1:0] shreg;
    logic              start, acc_clr, acc_en, acc_q, done, abort_nx;
    assign start = bit_vld & sof;
    assign busy  = state != IDLE;
    par_acc u_par_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (bit_in),
        .q   (acc_q)
    );
    // sof always wins: a new frame restarts from any state, aborting if one was open
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        done     = 1'b0;
        abort_nx = 1'b0;
        if (start) begin
            state_nx = DATA;
            cnt_nx   = CW'(1);
            acc_clr  = 1'b1;
            acc_en   = 1'b1;
            abort_nx = state != IDLE;
        end else if (bit_vld && state == DATA) begin
            acc_en   = 1'b1;
            cnt_nx   = cnt + 1'b1;
            state_nx = (cnt == CW'(DATA_W - 1)) ? PAR : DATA;
        end else if (bit_vld && state == PAR) begin
            done     = 1'b1;
            acc_clr  = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_vld  <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            frame_vld <= done;
            abort     <= abort_nx;
            if (start)
                shreg <= DATA_W'(bit_in);
            else if (bit_vld && state == DATA)
                shreg <= shreg | (DATA_W'(bit_in) << cnt);
            if (done) begin
                data_out   <= shreg;
                parity_err <= acc_q ^ bit_in ^ (PARITY_ODD != 0);
            end
        end
    end
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: scoreboard bench driving even and odd parity receivers in parallel
module tb_parity_frame_rx;
    logic       clk = 1'b0, rst = 1'b1, sof = 1'b0, bit_in = 1'b0, bit_vld = 1'b0;
    logic [7:0] data_e, data_o;
    logic       fv_e, fv_o, perr_e, perr_o, ab_e, ab_o, busy_e, busy_o;
    logic [8:0] q_e[$], q_o[$];
    int         errors = 0, checks = 0;
    int         frames_e = 0, frames_o = 0, aborts_e = 0, aborts_o = 0;
    int         exp_frames = 0, exp_aborts = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .sof(sof), .bit_in(bit_in), .bit_vld(bit_vld),
        .data_out(data_e), .frame_vld(fv_e), .parity_err(perr_e), .abort(ab_e), .busy(busy_e)
    );
    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .sof(sof), .bit_in(bit_in), .bit_vld(bit_vld),
        .data_out(data_o), .frame_vld(fv_o), .parity_err(perr_o), .abort(ab_o), .busy(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        logic [8:0] x;
        if (fv_e) begin
            chk("excl_e", ab_e, 0);
            if (q_e.size() == 0) chk("sb_e_unexpected", fv_e, 0);
            else begin
                x = q_e.pop_front();
                chk("data_e", data_e, x[7:0]);
                chk("perr_e", perr_e, x[8]);
            end
            frames_e++;
        end
        if (fv_o) begin
            chk("excl_o", ab_o, 0);
            if (q_o.size() == 0) chk("sb_o_unexpected", fv_o, 0);
            else begin
                x = q_o.pop_front();
                chk("data_o", data_o, x[7:0]);
                chk("perr_o", perr_o, x[8]);
            end
            frames_o++;
        end
        if (ab_e) aborts_e++;
        if (ab_o) aborts_o++;
    end

    task automatic bit_cyc(input logic s, input logic b);
        sof = s; bit_in = b; bit_vld = 1'b1;
        @(posedge clk); #1;
        sof = 1'b0; bit_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int gmax);
        bit_cyc(1'b1, d[0]);
        for (int i = 1; i < 8; i++) begin
            idle(gmax > 0 ? int'($urandom_range(0, gmax)) : 0);
            if (gmax > 0) chk("busy_gap", busy_e, 1);
            bit_cyc(1'b0, d[i]);
        end
        idle(gmax > 0 ? int'($urandom_range(0, gmax)) : 0);
        if (gmax > 0) chk("busy_par", busy_e, 1);
        q_e.push_back({^d ^ p, d});
        q_o.push_back({~(^d ^ p), d});
        exp_frames++;
        bit_cyc(1'b0, p);
    endtask

    initial begin
        #12;
        chk("rst_data", data_e, 0);
        chk("rst_fv", fv_e, 0);
        chk("rst_busy", busy_e, 0);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);
        send_frame(8'hA5, 1'b0, 0);
        idle(2);
        send_frame(8'hA5, 1'b1, 0);
        idle(1);
        send_frame(8'hA5, 1'b0, 5);
        idle(2);
        bit_cyc(1'b1, 1'b1);
        bit_cyc(1'b0, 1'b0);
        bit_cyc(1'b0, 1'b1);
        exp_aborts++;
        send_frame(8'h3C, 1'b0, 0);
        idle(2);
        chk("aborts_e", aborts_e, exp_aborts);
        chk("aborts_o", aborts_o, exp_aborts);
        bit_cyc(1'b1, 1'b1);
        bit_cyc(1'b0, 1'b0);
        bit_cyc(1'b0, 1'b1);
        bit_cyc(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", data_e, 0);
        chk("mid_rst_perr", perr_e, 0);
        chk("mid_rst_fv", fv_e, 0);
        chk("mid_rst_ab", ab_e, 0);
        chk("mid_rst_busy", busy_e, 0);
        chk("mid_rst_data_o", data_o, 0);
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 9; i++) bit_cyc(1'b0, 1'b1);
        chk("ignore_busy", busy_e, 0);
        send_frame(8'h01, 1'b0, 0);
        send_frame(8'h01, 1'b1, 0);
        idle(3);
        chk("frames_e", frames_e, exp_frames);
        chk("frames_o", frames_o, exp_frames);
        chk("aborts_e_end", aborts_e, exp_aborts);
        chk("q_e_left", q_e.size(), 0);
        chk("q_o_left", q_o.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
